// File: rtl/pong_pkg.sv
// Shared timing and colour constants for the pong raster path.
package pong_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] COLOR_BALL = 12'hFFF;
  localparam logic [11:0] COLOR_P1   = 12'hF00;
  localparam logic [11:0] COLOR_P2   = 12'h00F;
  localparam logic [11:0] COLOR_NET  = 12'h888;
  localparam logic [11:0] COLOR_BG   = 12'h000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with sync and visible-area decode.
module vga_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BACK   = 48,
  localparam int unsigned Total = ACTIVE + FRONT + SYNC + BACK,
  localparam int unsigned CntW  = $clog2(Total)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [CntW-1:0] cnt,
  output logic            wrap,
  output logic            in_sync,
  output logic            in_active
);

  localparam logic [CntW-1:0] Last      = CntW'(Total - 1);
  localparam logic [CntW-1:0] SyncFirst = CntW'(ACTIVE + FRONT);
  localparam logic [CntW-1:0] SyncLast  = CntW'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CntW-1:0] ActEnd    = CntW'(ACTIVE);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Advance on enable, wrapping to zero after the last position of the axis.
  always_comb begin
    wrap  = (cnt_q == Last);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign in_sync   = (cnt_q >= SyncFirst) && (cnt_q <= SyncLast);
  assign in_active = (cnt_q < ActEnd);

endmodule

// File: rtl/vga_scan.sv
// Raster source: pixel divider, h/v counters, object colour mux and registered pin stage.
module vga_scan #(
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned H_ACTIVE = pong_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT  = pong_pkg::H_FRONT,
  parameter int unsigned H_SYNC   = pong_pkg::H_SYNC,
  parameter int unsigned H_BACK   = pong_pkg::H_BACK,
  parameter int unsigned V_ACTIVE = pong_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT  = pong_pkg::V_FRONT,
  parameter int unsigned V_SYNC   = pong_pkg::V_SYNC,
  parameter int unsigned V_BACK   = pong_pkg::V_BACK,
  localparam int unsigned RowW    = $clog2(V_ACTIVE),
  localparam int unsigned ColW    = $clog2(H_ACTIVE)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [RowW-1:0] row,
  output logic [ColW-1:0] col,
  output logic            active,
  input  logic            ball_present,
  input  logic            paddle1_present,
  input  logic            paddle2_present,
  output logic [3:0]      red,
  output logic [3:0]      green,
  output logic [3:0]      blue,
  output logic            hsync,
  output logic            vsync,
  output logic            frame_start
);
  import pong_pkg::*;

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HCntW  = $clog2(HTotal);
  localparam int unsigned VCntW  = $clog2(VTotal);
  localparam int unsigned DivW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DivW-1:0]  DivLast = DivW'(PIX_DIV - 1);
  localparam logic [HCntW-1:0] HNetL   = HCntW'(H_ACTIVE / 2 - 1);
  localparam logic [HCntW-1:0] HNetR   = HCntW'(H_ACTIVE / 2);
  // Net is drawn on rows whose bit 3 is clear (8-row dashes).
  localparam logic [VCntW-1:0] VDash   = VCntW'(8);

  logic [DivW-1:0]  div_q, div_d;
  logic             pix_en;
  logic [HCntW-1:0] h_cnt;
  logic [VCntW-1:0] v_cnt;
  logic             h_wrap, h_sync, h_act;
  logic             v_wrap, v_sync, v_act;
  logic             net;
  logic [11:0]      colour;
  rgb_t             rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  // Pixel-enable divider: one pix_en every PIX_DIV board clocks.
  always_comb begin
    pix_en = (div_q == DivLast);
    div_d  = pix_en ? '0 : div_q + 1'b1;
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE),
    .FRONT (H_FRONT),
    .SYNC  (H_SYNC),
    .BACK  (H_BACK)
  ) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pix_en),
    .cnt      (h_cnt),
    .wrap     (h_wrap),
    .in_sync  (h_sync),
    .in_active(h_act)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE),
    .FRONT (V_FRONT),
    .SYNC  (V_SYNC),
    .BACK  (V_BACK)
  ) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pix_en && h_wrap),
    .cnt      (v_cnt),
    .wrap     (v_wrap),
    .in_sync  (v_sync),
    .in_active(v_act)
  );

  assign active      = h_act && v_act;
  assign row         = active ? v_cnt[RowW-1:0] : '0;
  assign col         = active ? h_cnt[ColW-1:0] : '0;
  assign frame_start = pix_en && h_wrap && v_wrap;

  // Colour priority: ball over paddles over net over background.
  always_comb begin
    net = ((h_cnt == HNetL) || (h_cnt == HNetR)) && ((v_cnt & VDash) == '0);
    if (ball_present) begin
      colour = COLOR_BALL;
    end else if (paddle1_present) begin
      colour = COLOR_P1;
    end else if (paddle2_present) begin
      colour = COLOR_P2;
    end else if (net) begin
      colour = COLOR_NET;
    end else begin
      colour = COLOR_BG;
    end
  end

  // Output stage: capture colour and syncs once per pixel, hold in between.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      rgb_d   = active ? rgb_t'(colour) : rgb_t'(COLOR_BG);
      hsync_d = ~h_sync;
      vsync_d = ~v_sync;
    end
  end

  // Divider and pin registers; reset drops any sync pulse in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule
